// File: rtl/microwave_ctrl.sv
// ============================================================================
// Module   : microwave_ctrl
// Brief    : Cook-cycle controller driving a countdown digit chain, magnetron
//            and buzzer. Optional lamp output enabled by MICROWAVE_LAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microwave_ctrl #(
    parameter int TICK_DIV    = 4,
    parameter int BEEP_CYCLES = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       load_req,
    input  logic       timer_zero,
    output logic       timer_en,
    output logic       timer_clr,
    output logic       timer_loadn,
    output logic       mag_on,
    output logic       beep,
`ifdef MICROWAVE_LAMP_EN
    output logic       lamp,
`endif
    output logic [1:0] state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] c_BEEP_LAST = BW'(BEEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_nxt;
    logic [BW-1:0] r_beep_cnt;
    logic [BW-1:0] w_beep_nxt;
    logic          w_en_nxt;
    logic          w_clr_nxt;
    logic          w_loadn_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_beep_nxt  = r_beep_cnt;
        w_en_nxt    = 1'b0;
        w_clr_nxt   = 1'b0;
        w_loadn_nxt = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_loadn_nxt = ~load_req;
                if (start && door_closed && !timer_zero && !stop) begin
                    w_state_nxt = S_COOK;
                    w_tick_nxt  = '0;
                end
            end
            S_COOK: begin
                // The tick counter advances even on the exit edge, so a wrap
                // there still produces its decrement pulse.
                w_en_nxt   = (r_tick == c_TICK_LAST);
                w_tick_nxt = (r_tick == c_TICK_LAST) ? '0 : r_tick + TW'(1);
                if (timer_zero) begin
                    w_state_nxt = S_DONE;
                    w_beep_nxt  = '0;
                end else if (!door_closed || stop) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                    w_tick_nxt  = '0;
                end else if (start && door_closed) begin
                    w_state_nxt = S_COOK;
                end
            end
            S_DONE: begin
                if (stop || !door_closed || (r_beep_cnt == c_BEEP_LAST)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_beep_nxt = r_beep_cnt + BW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state output.
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_beep_cnt  <= '0;
            timer_en    <= 1'b0;
            timer_clr   <= 1'b0;
            timer_loadn <= 1'b1;
            mag_on      <= 1'b0;
            beep        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_beep_cnt  <= w_beep_nxt;
            timer_en    <= w_en_nxt;
            timer_clr   <= w_clr_nxt;
            timer_loadn <= w_loadn_nxt;
            mag_on      <= (w_state_nxt == S_COOK);
            beep        <= (w_state_nxt == S_DONE);
        end
    end

`ifdef MICROWAVE_LAMP_EN
    always_ff @(posedge clk) begin
        if (clrn) begin
            lamp <= 1'b0;
        end else begin
            lamp <= !door_closed || (w_state_nxt == S_COOK) || (w_state_nxt == S_PAUSE);
        end
    end
`endif

    assign state = r_state;

endmodule

`default_nettype wire
